rom_read_arbiter: RTL
=====================

Name: rom_read_arbiter

Overview:
- Shares one registered-address, registered-data single-port ROM (2-cycle read latency) between NUM_REQ independent read requesters.
- Arbitrates one read per cycle and drives the ROM address.
- Tags each issued read with the requester index and routes returned data back on a shared response bus with a per-requester valid strobe.
- Sits between the ROM instance and its clients in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- READ_LATENCY, 2, cycles from address presented to ROM until data valid at ROM output; fixed by the ROM.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant; the request is accepted in the cycle where valid and ready are both high.
- rsp_valid  output  NUM_REQ  one-hot; data for requester i on rsp_data this cycle.
- rsp_data  output  DATA_WIDTH  shared response data.
- rom_addr  output  ADDR_WIDTH  to ROM addr.
- rom_data  input  DATA_WIDTH  from ROM data_out.
- rd_count  output  16  total accepted reads, saturating at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): req_ready=0, rsp_valid=0, rsp_data=0, rd_count=0, pipeline valids cleared, RR pointer=NUM_REQ-1 so requester 0 has highest priority first.
- Reset mid-operation: in-flight reads are discarded and produce no rsp_valid after release.
- Arbitration is combinational on the current req_valid.
  - req_ready is a one-hot subset of req_valid; all zero when no request.
  - req_ready never depends on rsp state: no backpressure, clients must sink responses.
- rom_addr = address of the granted requester in the same cycle. With no grant, rom_addr holds the last granted address (registered copy, reset 0), so the idle ROM address does not toggle.
- Issue pipeline: READ_LATENCY-deep shift register of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 captures the grant at the edge that ends grant cycle T.
  - rsp_valid[id] and rsp_data=rom_data are asserted combinationally from the last stage in cycle T+READ_LATENCY (T+2 by default), for exactly one cycle per accepted read.
- rsp_data = 0 when no rsp_valid bit is set.
- Throughput: one read per cycle sustained; back-to-back grants, to the same or different requesters, produce back-to-back responses in issue order.
- A requester may hold req_valid with changing req_addr; only the address in the accept cycle is used.
- rd_count increments by 1 per accepted read and stops at 16'hFFFF (no wrap).
- Arbitration policy (see Optional Feature):
  - Round-robin: search starts at pointer+1 modulo NUM_REQ. The pointer updates to the granted index only when a grant occurs. The wrap from NUM_REQ-1 to 0 is required.

Optional Feature:
- Macro ROM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as above, so no requester starves under continuous contention.
- Undefined: fixed priority, lowest index wins every cycle. The RR pointer and its register are not built; all other timing is identical.

Decomposition:
- Package rom_arb_pkg:
  - localparam ID_W = $clog2(NUM_REQ) default helper function.
  - typedef struct packed {logic valid; logic [ID_W-1:0] id;} issue_tag_t.
- Sub-module rom_arb_pick: a combinational picker taking req_valid and pointer, producing a one-hot grant and a binary index. It contains both the RR and the fixed-priority variants under the macro.
- rom_read_arbiter holds the pipeline, the address mux/hold register and the counter.

Test Plan (ROM preloaded mem[i]=i for i=0..19):
- Single request: req_valid=4'b0001, addr0=5 for one cycle at T -> req_ready=4'b0001 at T; rom_addr=5 at T; rsp_valid=4'b0001, rsp_data=8'h05 at T+2; nothing else.
- Full contention, RR build: all four valid continuously, addr_i=10+i -> grants 0,1,2,3,0,... on consecutive cycles; rsp_data 0A,0B,0C,0D,0A at T+2..T+6 with matching one-hot rsp_valid.
- Same contention, fixed-priority build -> req_ready=4'b0001 every cycle; rsp_valid=4'b0001 with data 0A every cycle from T+2.
- Back-to-back single requester: requester 2 addrs 1,2,3 on cycles T..T+2 -> rsp_valid[2] high T+2..T+4 with data 01,02,03; rom_addr holds 3 after T+2.
- Reset mid-flight: grant at T, rst_n low at T+1 for one cycle -> rsp_valid stays 0 through T+4; rd_count=0; the first post-reset grant goes to requester 0.
- Counter saturation: force 65536 accepted reads -> rd_count reads 16'hFFFF and stays there on the next read.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read arbiter: issue-tag layout and requester-id width.
// ID_W is sized for the largest supported requester count, so one tag format serves every build.
package rom_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 8; k++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    localparam int ID_W = id_width(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } issue_tag_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Purpose: combinational one-hot picker; round-robin when ROM_ARB_ROUND_ROBIN_EN is defined, else fixed priority.
// Latency: zero (pure combinational).
// Backpressure: none; the grant depends only on req_valid and the pointer.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    int cand;

    // Search starts one past the last winner and wraps, so the last winner is tried last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld       = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = ID_W'(cand);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
                grant_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Purpose: shares one 2-cycle single-port ROM among NUM_REQ readers; ROM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: grant and rom_addr same cycle; rsp_valid/rsp_data READ_LATENCY cycles after the accept.
// Backpressure: none; one read accepted per cycle, clients must sink every response.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [15:0]                   rd_count
);

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_vld;
    logic [ID_W-1:0]       ptr;

    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [15:0]           rd_count_q, rd_count_d;
    issue_tag_t            pipe_q [READ_LATENCY];
    issue_tag_t            pipe_d [READ_LATENCY];
    issue_tag_t            last_tag;

    rom_arb_pick #(
        .NUM_REQ   (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = grant_idx;
        end
    end

    // Pointer resets to the top index so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign req_ready = grant;

    // Idle cycles replay the last granted address so the ROM input stays quiet.
    always_comb begin
        rom_addr = addr_hold_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rom_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        addr_hold_d = rom_addr;
    end

    always_comb begin
        rd_count_d = rd_count_q;
        if (grant_vld && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_comb begin
        pipe_d[0].valid = grant_vld;
        pipe_d[0].id    = grant_idx;
        for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_q <= '0;
            rd_count_q  <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            addr_hold_q <= addr_hold_d;
            rd_count_q  <= rd_count_d;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    assign last_tag = pipe_q[READ_LATENCY-1];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (last_tag.valid) begin
            rsp_data = rom_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_tag.id == ID_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

    assign rd_count = rd_count_q;

endmodule
